imem_boot_ctrl: RTL and testbench

//  Boot/load controller for the core's instruction memory. Streams words from the external

---
 rtl/imem_boot_ctrl.sv | 143 ++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot loader: fetches words from the external source into imem
// and holds the core stalled until the image is complete.
module imem_boot_ctrl #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          AW          = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          TIMEOUT     = 15,
    parameter bit          AUTOBOOT    = 1'b1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          exIns_valid,
    input  logic [31:0]   exIns_in,
    output logic          exIns_ren,
    output logic [31:0]   exIns_addr,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          core_stall,
    output logic          load_done,
    output logic          load_err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;

    localparam int          WW        = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH_WORDS);
    localparam state_t      RST_STATE = AUTOBOOT ? S_LOAD : S_IDLE;
    localparam logic [AW:0] RST_LEN   = AUTOBOOT ? DEPTH_L : '0;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          ren_q, ren_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          stall_q, stall_d;

    logic [AW:0]   len_clamp;
    logic          accept;
    logic          last_word;
    logic [WW-1:0] wait_inc;

    assign len_clamp = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign accept    = ren_q & exIns_valid;
    assign last_word = ({1'b0, idx_q} == (len_q - 1'b1));
    assign wait_inc  = wait_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        wait_d  = wait_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (load_start) begin
                    if (len_clamp != '0) begin
                        state_d = S_LOAD;
                        len_d   = len_clamp;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else begin
                        // Zero-length load reuses the FLUSH->DONE tail with nothing to write
                        state_d = S_FLUSH;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = idx_q;
                    wdata_d = exIns_in;
                    wait_d  = '0;
                    if (last_word) state_d = S_FLUSH;
                    else           idx_d   = idx_q + 1'b1;
                end else if (ren_q) begin
                    wait_d = wait_inc;
                    if (wait_inc == WW'(TIMEOUT)) state_d = S_ERR;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q
        ren_d   = (state_d == S_LOAD);
        addr_d  = ren_d ? (BASE_ADDR + 32'({idx_d, 2'b00})) : addr_q;
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        stall_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= RST_STATE;
            idx_q   <= '0;
            len_q   <= RST_LEN;
            wait_q  <= '0;
            ren_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= AUTOBOOT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            wait_q  <= wait_d;
            ren_q   <= ren_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign exIns_ren  = ren_q;
    assign exIns_addr = addr_q;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_stall = stall_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: scoreboard of accepted words vs. imem writes, plus a
// table of load scenarios and hand-written reset/autoboot/timeout sequences.
module tb_imem_boot_ctrl;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0;

    logic          clk = 1'b0;
    logic          nrst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          exIns_valid;
    logic [31:0]   exIns_in;
    logic          exIns_ren;
    logic [31:0]   exIns_addr;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_stall;
    logic          load_done;
    logic          load_err;

    imem_boot_ctrl #(
        .DEPTH_WORDS(256), .AW(AW), .BASE_ADDR(BASE), .TIMEOUT(15), .AUTOBOOT(1'b1)
    ) dut (
        .clk(clk), .nrst(nrst), .load_start(load_start), .load_len(load_len),
        .exIns_valid(exIns_valid), .exIns_in(exIns_in), .exIns_ren(exIns_ren),
        .exIns_addr(exIns_addr), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_stall(core_stall), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] idx; logic [31:0] data; } wr_t;
    typedef struct { logic [AW:0] len; int mode; int stop_after; int exp_writes; bit exp_err; } vec_t;
    typedef struct { int acc; int last_acc_it; int done_it; int err_it; int end_it; int done_n; } res_t;

    int   total = 0;
    int   bad = 0;
    int   writes_seen = 0;
    wr_t  exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Every imem write must match the oldest accepted word not yet written
    always @(negedge clk) begin : monitor
        wr_t e;
        if (nrst && imem_we) begin
            writes_seen++;
            chk("stall_during_write", 32'(core_stall), 32'd1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual_waddr=%0d required=none", imem_waddr);
            end else begin
                e = exp_q.pop_front();
                chk("imem_waddr", 32'(imem_waddr), e.idx);
                chk("imem_wdata", imem_wdata, e.data);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ren"},   32'(exIns_ren),  32'd0);
        chk({tag, "_addr"},  exIns_addr,      32'd0);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_done"},  32'(load_done),  32'd0);
        chk({tag, "_err"},   32'(load_err),   32'd0);
        chk({tag, "_stall"}, 32'(core_stall), 32'd1);
    endtask

    // mode 0: valid always high, data 0x1000_0000+i; mode 1: valid alternates;
    // mode 2: random valid plus an in-flight load_start that must be ignored
    task automatic run_load(input string tag, input bit do_start, input logic [AW:0] len,
                            input int mode, input int stop_after, input int abort_after,
                            output res_t r);
        int  idle;
        bit  v;
        bit  finished;
        wr_t e;
        r = '{0, -1, -1, -1, -1, 0};
        idle = 0;
        finished = 1'b0;
        if (do_start) begin
            @(negedge clk);
            load_start = 1'b1;
            load_len   = len;
            exIns_valid = 1'b0;
        end
        for (int it = 0; it < 1200; it++) begin
            @(negedge clk);
            load_start = 1'b0;
            if (mode == 2 && it == 5) begin
                load_start = 1'b1;
                load_len   = 9'd7;
            end
            if (load_done) begin
                r.done_n++;
                r.done_it = it;
            end
            if (load_err) begin
                r.err_it = it;
                finished = 1'b1;
                break;
            end
            if (r.done_n > 0 && !core_stall) begin
                r.end_it = it;
                finished = 1'b1;
                break;
            end
            if (abort_after >= 0 && r.acc >= abort_after) begin
                finished = 1'b1;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (it % 2 == 0);
                default: v = ($urandom_range(0, 99) < 60) || (idle >= 8);
            endcase
            if (stop_after >= 0 && r.acc >= stop_after) v = 1'b0;
            exIns_valid = v;
            exIns_in = (mode == 0) ? (32'h1000_0000 + 32'(r.acc)) : $urandom;
            if (exIns_ren) begin
                chk({tag, "_exIns_addr"}, exIns_addr, BASE + 32'(r.acc * 4));
                if (v) begin
                    e.idx  = 32'(r.acc);
                    e.data = exIns_in;
                    exp_q.push_back(e);
                    r.acc++;
                    r.last_acc_it = it;
                    idle = 0;
                end else begin
                    idle++;
                end
            end
        end
        exIns_valid = 1'b0;
        load_start  = 1'b0;
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL %s_budget actual=expired required=completion", tag);
        end
    endtask

    task automatic check_run(input string tag, input res_t r, input int w0,
                             input int exp_writes, input bit exp_err);
        chk({tag, "_accepts"}, 32'(r.acc), 32'(exp_writes));
        chk({tag, "_writes"},  32'(writes_seen - w0), 32'(exp_writes));
        chk({tag, "_err_seen"}, 32'(r.err_it >= 0), 32'(exp_err));
        if (exp_err) begin
            chk({tag, "_err_latency"}, 32'(r.err_it - r.last_acc_it), 32'd16);
            chk({tag, "_err_ren"},   32'(exIns_ren),  32'd0);
            chk({tag, "_err_stall"}, 32'(core_stall), 32'd1);
        end else begin
            chk({tag, "_done_pulses"}, 32'(r.done_n), 32'd1);
            chk({tag, "_done_latency"}, 32'(r.done_it - r.last_acc_it), 32'd2);
            chk({tag, "_stall_drop"}, 32'(r.end_it - r.done_it), 32'd1);
            chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        res_t r;
        int   w0;
        vecs[0] = '{9'd4,   1, -1, 4,   1'b0};
        vecs[1] = '{9'd3,   1,  2, 2,   1'b1};
        vecs[2] = '{9'd5,   2, -1, 5,   1'b0};
        vecs[3] = '{9'd0,   0, -1, 0,   1'b0};
        vecs[4] = '{9'd300, 0, -1, 256, 1'b0};
        vecs[5] = '{9'd17,  2, -1, 17,  1'b0};
        vecs[6] = '{9'd40,  2, -1, 40,  1'b0};

        nrst = 1'b0;
        load_start = 1'b0;
        load_len = '0;
        exIns_valid = 1'b0;
        exIns_in = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");

        nrst = 1'b1;
        w0 = writes_seen;
        run_load("autoboot", 1'b0, '0, 0, -1, -1, r);
        check_run("autoboot", r, w0, 256, 1'b0);

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            w0 = writes_seen;
            run_load(tag, 1'b1, vecs[i].len, vecs[i].mode, vecs[i].stop_after, -1, r);
            check_run(tag, r, w0, vecs[i].exp_writes, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                repeat (5) @(negedge clk);
                chk({tag, "_err_held"},   32'(load_err),   32'd1);
                chk({tag, "_err_stall2"}, 32'(core_stall), 32'd1);
                chk({tag, "_err_we"},     32'(imem_we),    32'd0);
            end
        end

        // Reset in the middle of a load, then the autoboot load restarts from the base address
        run_load("midload", 1'b1, 9'd50, 0, -1, 10, r);
        chk("midload_accepts", 32'(r.acc), 32'd10);
        #2 nrst = 1'b0;
        #1 chk_reset_vals("midrst");
        exp_q.delete();
        @(negedge clk);
        nrst = 1'b1;
        w0 = writes_seen;
        run_load("reboot", 1'b0, '0, 0, -1, -1, r);
        check_run("reboot", r, w0, 256, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
